// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral: burst read/write access to NUM_REGS x DATA_W registers.
// All pins are synchronised into clk; the frame is decoded from detected sclk edges.
module spi_regfile #(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = $clog2(ADDR_W + 1);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]   NREGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [BW-1:0]     BLAST = BW'(DATA_W - 1);
  localparam logic [AW-1:0]     ALAST = AW'(ADDR_W - 1);

  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sq, copi_sq, ncs_sq;
  logic                   sclk_pq, ncs_pq;
  logic [SYNC_STAGES:0]   vld_q;

  state_t              state_q;
  logic                cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [AW-1:0]       acnt_q;
  logic [BW-1:0]       bcnt_q;
  logic [DATA_W-1:0]   sh_q;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                wr_stb_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                cipo_q;
  logic                oe_q;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, sclk_fall, ncs_fall;
  logic in_range;
  logic [IW-1:0]     idx;
  logic [ADDR_W-1:0] addr_inc_d;
  logic [DATA_W-1:0] wr_word_d;
  logic [DATA_W-1:0] rd_word_d;
  logic [DATA_W-1:0] rd_next_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sq <= '0;
      copi_sq <= '0;
      ncs_sq  <= '1;
      sclk_pq <= 1'b0;
      ncs_pq  <= 1'b1;
      vld_q   <= '0;
    end else begin
      sclk_sq <= {sclk_sq[SYNC_STAGES-2:0], sclk};
      copi_sq <= {copi_sq[SYNC_STAGES-2:0], copi};
      ncs_sq  <= {ncs_sq[SYNC_STAGES-2:0], ncs};
      sclk_pq <= sclk_sq[SYNC_STAGES-1];
      ncs_pq  <= ncs_sq[SYNC_STAGES-1];
      vld_q   <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_sq[SYNC_STAGES-1];
  assign copi_s    = copi_sq[SYNC_STAGES-1];
  assign ncs_s     = ncs_sq[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_pq;
  assign sclk_fall = ~sclk_s & sclk_pq;
  // Only a fall seen through a chain holding real pin samples opens a frame,
  // so a frame already running when reset lifts is ignored.
  assign ncs_fall  = (&vld_q) & ncs_pq & ~ncs_s;

  assign in_range   = {1'b0, addr_q} < NREGS;
  assign idx        = addr_q[IW-1:0];
  assign addr_inc_d = (addr_q == LAST) ? '0 : addr_q + 1'b1;
  assign wr_word_d  = DATA_W'({sh_q, copi_s});
  assign rd_word_d  = in_range ? regs_q[idx] : '0;
  assign rd_next_d  = rd_q << 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= 1'b0;
      addr_q    <= '0;
      acnt_q    <= '0;
      bcnt_q    <= '0;
      sh_q      <= '0;
      rd_q      <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      cipo_q    <= 1'b0;
      oe_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cipo_q <= 1'b0;
          oe_q   <= 1'b0;
          if (ncs_fall) state_q <= CMD;
        end
        CMD: begin
          if (ncs_s) begin
            state_q <= IDLE;
          end else if (sclk_rise) begin
            cmd_q   <= copi_s;
            acnt_q  <= '0;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (ncs_s) begin
            state_q <= IDLE;
          end else if (sclk_rise) begin
            addr_q <= ADDR_W'({addr_q, copi_s});
            acnt_q <= acnt_q + 1'b1;
            if (acnt_q == ALAST) begin
              bcnt_q  <= '0;
              oe_q    <= ~cmd_q;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (ncs_s) begin
            state_q <= IDLE;
            cipo_q  <= 1'b0;
            oe_q    <= 1'b0;
          end else if (sclk_rise) begin
            bcnt_q <= (bcnt_q == BLAST) ? '0 : bcnt_q + 1'b1;
            if (cmd_q) sh_q <= wr_word_d;
            if (bcnt_q == BLAST) begin
              addr_q <= addr_inc_d;
              if (cmd_q && in_range) begin
                regs_q[idx] <= wr_word_d;
                wr_stb_q    <= 1'b1;
                wr_addr_q   <= addr_q;
              end
            end
          end else if (sclk_fall && !cmd_q) begin
            // First fall of each word reloads from the current address.
            if (bcnt_q == '0) begin
              rd_q   <= rd_word_d;
              cipo_q <= rd_word_d[DATA_W-1];
            end else begin
              rd_q   <= rd_next_d;
              cipo_q <= rd_next_d[DATA_W-1];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_img
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo    = cipo_q;
  assign cipo_oe = oe_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Bench for spi_regfile: table of SPI frames with expected register image,
// strobe count and readback words fed through a scoreboard queue.
module tb_spi_regfile;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n, sclk, copi, ncs;
  logic        cipo, cipo_oe, wr_stb;
  logic [63:0] regs;
  logic [6:0]  wr_addr;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int stb_cnt = 0;
  logic oe_all;
  logic [7:0] exp_q [$];

  spi_regfile dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs),
    .wr_stb(wr_stb), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_stb) stb_cnt <= stb_cnt + 1;

  typedef struct {
    bit          wr;
    logic [6:0]  a;
    int          n;
    logic [23:0] d;
    logic [23:0] rd;
    int          stb;
    logic [6:0]  wa;
    logic [63:0] img;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int nb, output logic [31:0] rx);
    rx = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      logic r;
      copi = v[i];
      clks(H);
      r = cipo;
      oe_all &= cipo_oe;
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
      rx = {rx[30:0], r};
    end
  endtask

  task automatic frame(input bit wr, input logic [6:0] a, input int n, input logic [23:0] d);
    logic [31:0] rx;
    ncs = 1'b0;
    clks(H);
    send_bits({31'b0, wr}, 1, rx);
    chk("oe_in_addr", {63'b0, cipo_oe}, 64'd0);
    send_bits({25'b0, a}, 7, rx);
    for (int k = 0; k < n; k++) begin
      oe_all = 1'b1;
      send_bits({24'b0, d[23-8*k -: 8]}, 8, rx);
      if (!wr) begin
        chk("rd_word", {56'b0, rx[7:0]}, {56'b0, exp_q.pop_front()});
        chk("rd_oe", {63'b0, oe_all}, 64'd1);
      end
    end
    clks(H);
    ncs = 1'b1;
    clks(6);
    chk("oe_after", {62'b0, cipo_oe, cipo}, 64'd0);
  endtask

  vec_t vt [8];

  initial begin
    logic [31:0] rx;
    int s;
    vt[0] = '{1'b1, 7'd2,   1, 24'hA50000, 24'h0,      1, 7'd2, 64'h0000_0000_00A5_0000};
    vt[1] = '{1'b1, 7'd6,   3, 24'h112233, 24'h0,      3, 7'd0, 64'h2211_0000_00A5_0033};
    vt[2] = '{1'b0, 7'd6,   2, 24'hFFFFFF, 24'h112200, 0, 7'd0, 64'h2211_0000_00A5_0033};
    vt[3] = '{1'b1, 7'd9,   1, 24'hFF0000, 24'h0,      0, 7'd0, 64'h2211_0000_00A5_0033};
    vt[4] = '{1'b0, 7'd9,   1, 24'hFFFFFF, 24'h000000, 0, 7'd0, 64'h2211_0000_00A5_0033};
    vt[5] = '{1'b0, 7'd7,   2, 24'hFFFFFF, 24'h223300, 0, 7'd0, 64'h2211_0000_00A5_0033};
    vt[6] = '{1'b1, 7'd127, 2, 24'h556600, 24'h0,      1, 7'd0, 64'h2211_0000_00A5_0066};
    vt[7] = '{1'b0, 7'd0,   3, 24'hFFFFFF, 24'h6600A5, 0, 7'd0, 64'h2211_0000_00A5_0066};

    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1; oe_all = 1'b1;
    clks(4);
    rst_n = 1'b1;
    clks(5);
    chk("rst_regs", regs, 64'd0);
    chk("rst_out", {56'b0, wr_stb, wr_addr}, 64'd0);
    chk("rst_cipo", {62'b0, cipo_oe, cipo}, 64'd0);

    for (int v = 0; v < 8; v++) begin
      s = stb_cnt;
      if (!vt[v].wr)
        for (int k = 0; k < vt[v].n; k++) exp_q.push_back(vt[v].rd[23-8*k -: 8]);
      frame(vt[v].wr, vt[v].a, vt[v].n, vt[v].d);
      chk($sformatf("v%0d_img", v), regs, vt[v].img);
      chk($sformatf("v%0d_stb", v), 64'(stb_cnt - s), 64'(vt[v].stb));
      chk($sformatf("v%0d_waddr", v), {57'b0, wr_addr}, {57'b0, vt[v].wa});
    end

    // Aborted write: ncs rises after 5 data bits.
    s = stb_cnt;
    ncs = 1'b0; clks(H);
    send_bits(32'd1, 1, rx);
    send_bits(32'd1, 7, rx);
    send_bits(32'h1F, 5, rx);
    clks(H); ncs = 1'b1; clks(8);
    chk("abort_regs", regs, 64'h2211_0000_00A5_0066);
    chk("abort_stb", 64'(stb_cnt - s), 64'd0);
    frame(1'b1, 7'd1, 1, 24'h3C0000);
    chk("after_abort_regs", regs, 64'h2211_0000_00A5_3C66);
    chk("after_abort_stb", 64'(stb_cnt - s), 64'd1);
    chk("after_abort_waddr", {57'b0, wr_addr}, 64'd1);

    // Reset during a read frame drops cipo_oe.
    ncs = 1'b0; clks(H);
    send_bits(32'd0, 1, rx);
    send_bits(32'd2, 7, rx);
    send_bits(32'd0, 1, rx);
    chk("rd_oe_pre_rst", {63'b0, cipo_oe}, 64'd1);
    rst_n = 1'b0; clks(1);
    chk("rd_rst_oe", {62'b0, cipo_oe, cipo}, 64'd0);
    chk("rd_rst_regs", regs, 64'd0);
    clks(1); rst_n = 1'b1;
    ncs = 1'b1; clks(10);

    // Reset mid-burst after one committed word; frame continues but is ignored.
    s = stb_cnt;
    ncs = 1'b0; clks(H);
    send_bits(32'd1, 1, rx);
    send_bits(32'd3, 7, rx);
    send_bits(32'h77, 8, rx);
    clks(4);
    chk("burst_w0", {56'b0, regs[31:24]}, 64'h77);
    chk("burst_w0_stb", 64'(stb_cnt - s), 64'd1);
    send_bits(32'h4, 3, rx);
    rst_n = 1'b0; clks(2); rst_n = 1'b1; clks(1);
    chk("mid_rst_regs", regs, 64'd0);
    chk("mid_rst_out", {55'b0, cipo_oe, wr_stb, wr_addr}, 64'd0);
    s = stb_cnt;
    send_bits(32'h08, 5, rx);
    send_bits(32'h99, 8, rx);
    clks(H); ncs = 1'b1; clks(8);
    chk("ignored_regs", regs, 64'd0);
    chk("ignored_stb", 64'(stb_cnt - s), 64'd0);

    frame(1'b1, 7'd4, 1, 24'h9A0000);
    chk("post_rst_regs", regs, 64'h0000_009A_0000_0000);
    chk("post_rst_waddr", {57'b0, wr_addr}, 64'd4);
    exp_q.push_back(8'h9A);
    frame(1'b0, 7'd4, 1, 24'hFFFFFF);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
